// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP pixel transmitter: vertical state enum,
// RGB565 colour-bar constants and counter-width helper.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } dvp_state_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pixel_tx_timing_gen.sv
// Vertical state machine plus column/line counters for the DVP transmitter.
// Emits unregistered vsync/href/fetch/frame-start strobes one cycle ahead of the bus.
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_FRONT     = 4
) (
    input  logic cam_pclk,
    input  logic rst_n,
    input  logic enable_i,
    output logic vsync_o,
    output logic href_o,
    output logic fetch_o,
    output logic frame_start_o
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int TOTAL    = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int CW       = cnt_width(LINE_LEN);
    localparam int LW       = cnt_width(TOTAL);

    localparam logic [CW-1:0] COL_LAST   = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] HREF_END   = CW'(2 * H_ACTIVE);
    localparam logic [CW-1:0] FETCH_END  = CW'(2 * H_ACTIVE - 2);

    dvp_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d;
    logic [LW-1:0] line_last;
    logic          eol;
    logic          last_line;
    logic          next_line_active;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        col_d            = col_q;
        line_d           = line_q;
        line_last        = '0;
        eol              = (col_q == COL_LAST);
        last_line        = 1'b0;
        next_line_active = 1'b0;

        case (state_q)
            ST_VSYNC:  line_last = LW'(VSYNC_LINES - 1);
            ST_VBACK:  line_last = LW'(V_BACK - 1);
            ST_ACTIVE: line_last = LW'(V_ACTIVE - 1);
            ST_VFRONT: line_last = LW'(V_FRONT - 1);
            default:   line_last = '0;
        endcase
        last_line = (line_q == line_last);

        if (state_q == ST_IDLE) begin
            col_d  = '0;
            line_d = '0;
            if (enable_i) state_d = ST_VSYNC;
        end else begin
            col_d = eol ? '0 : col_q + CW'(1);
            if (eol) begin
                if (last_line) begin
                    line_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBACK;
                        ST_VBACK:  state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFRONT;
                        ST_VFRONT: state_d = enable_i ? ST_VSYNC : ST_IDLE;
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    line_d = line_q + LW'(1);
                end
            end
        end

        // The first fetch of a line lands on the last column of the line before it.
        next_line_active = (state_q == ST_VBACK && last_line) ||
                           (state_q == ST_ACTIVE && !last_line);
    end

    assign vsync_o       = (state_q == ST_VSYNC);
    assign href_o        = (state_q == ST_ACTIVE) && (col_q < HREF_END);
    assign frame_start_o = (state_q == ST_VSYNC) && (line_q == '0) && (col_q == '0);
    assign fetch_o       = (eol && next_line_active) ||
                           ((state_q == ST_ACTIVE) && col_q[0] && (col_q < FETCH_END));

endmodule

// File: rtl/dvp_pixel_tx.sv
// DVP (OV5640-style) transmitter: RGB565 stream in, registered vsync/href/byte bus out.
// Optional colour-bar generator enabled by defining DVP_TX_TEST_PATTERN_EN.
module dvp_pixel_tx
    import dvp_pkg::*;
#(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_BLANK     = 144,
    parameter int          V_ACTIVE    = 480,
    parameter int          VSYNC_LINES = 4,
    parameter int          V_BACK      = 16,
    parameter int          V_FRONT     = 4,
    parameter logic [15:0] FILL_PIXEL  = 16'h0000
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    input  logic        underflow_clr,
    output logic        frame_start,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        underflow
);

    logic raw_vsync, raw_href, raw_fetch, raw_frame_start;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .cam_pclk      (cam_pclk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .vsync_o       (raw_vsync),
        .href_o        (raw_href),
        .fetch_o       (raw_fetch),
        .frame_start_o (raw_frame_start)
    );

    logic        vsync_q, href_q, fs_q, ready_q, fetch_q, uf_q;
    logic        ready_d, uf_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] sel_pixel;

`ifdef DVP_TX_TEST_PATTERN_EN
    localparam int PW    = cnt_width(H_ACTIVE);
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic          test_mode_q;
    logic [PW-1:0] pix_idx_q, pix_idx_d;
    logic [31:0]   bar_raw;
    logic [2:0]    bar_idx;
    logic [15:0]   pattern_px;

    // test_mode only takes effect at a frame boundary; fetch_q keeps running so
    // the pixel index stays aligned to the line.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            test_mode_q <= 1'b0;
            pix_idx_q   <= '0;
        end else begin
            if (raw_frame_start) test_mode_q <= test_mode;
            pix_idx_q <= pix_idx_d;
        end
    end

    always_comb begin
        pix_idx_d = pix_idx_q;
        if (fetch_q) pix_idx_d = (pix_idx_q == PW'(H_ACTIVE - 1)) ? '0 : pix_idx_q + PW'(1);
        bar_raw    = 32'(pix_idx_q) / 32'(BAR_W);
        bar_idx    = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
        pattern_px = bar_color(bar_idx);
    end
`endif

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            fs_q    <= 1'b0;
            ready_q <= 1'b0;
            fetch_q <= 1'b0;
            uf_q    <= 1'b0;
            data_q  <= 8'h00;
            pix_q   <= 16'h0000;
        end else begin
            vsync_q <= raw_vsync;
            href_q  <= raw_href;
            fs_q    <= raw_frame_start;
            ready_q <= ready_d;
            fetch_q <= raw_fetch;
            uf_q    <= uf_d;
            data_q  <= data_d;
            pix_q   <= pix_d;
        end
    end

    // The high byte leaves on the same edge the pixel is accepted, so it is
    // taken straight from the selected source; the low byte comes from pix_q.
    always_comb begin
        ready_d   = raw_fetch;
        sel_pixel = pix_valid ? pix_data : FILL_PIXEL;
`ifdef DVP_TX_TEST_PATTERN_EN
        ready_d = raw_fetch & ~test_mode_q;
        if (test_mode_q) sel_pixel = pattern_px;
`endif
        pix_d  = fetch_q ? sel_pixel : pix_q;
        data_d = 8'h00;
        if (raw_href) data_d = fetch_q ? sel_pixel[15:8] : pix_q[7:0];

        uf_d = uf_q;
        if (ready_q && !pix_valid) uf_d = 1'b1;
        else if (underflow_clr)    uf_d = 1'b0;
    end

    assign dvp_vsync   = vsync_q;
    assign dvp_href    = href_q;
    assign dvp_data    = data_q;
    assign pix_ready   = ready_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule
